prescaled_counter: RTL and testbench
====================================

# prescaled_counter

Parametrised up/down counter with built-in prescaler, programmable wrap limit, synchronous load/clear, free-run or one-shot mode, and a registered top-bits output for LED/display drive. It is the general-purpose timebase and divider for board-level FPGA designs: blinkers, slow strobes, timeouts and periodic ticks for downstream logic.

## Interface
- WIDTH, 27: main counter width in bits (≥ 2).
- DIV, 1: prescaler modulus; the counter steps once per DIV enabled cycles (≥ 1).
- OUT_BITS, 4: number of counter MSBs presented on `out` (1..WIDTH).
- clkin  in  1  single clock, all logic on rising edge.
- rst0  in  1  asynchronous, active-high reset.
- ena0  in  1  count enable; low freezes prescaler and counter.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value taken on `load`.
- dir  in  1  1 = count up, 0 = count down.
- oneshot  in  1  1 = stop at terminal, 0 = wrap.
- limit  in  WIDTH  top of count range; range is 0..limit.
- cnt  out  WIDTH  current count.
- out  out  OUT_BITS  registered copy of cnt[WIDTH-1 -: OUT_BITS].
- tc  out  1  one-cycle terminal-count pulse.
- done  out  1  one-shot finished (level).

## Operation
- Priority per edge: rst0 > clr > load > step.
- rst0 high: cnt=0, prescaler=0, out=0, tc=0, done=0, state=RUN, held while high.
- clr: cnt=0, prescaler=0, tc=0, done=0, state=RUN; ignores ena0.
- load: cnt=load_val, prescaler=0, tc=0, done=0, state=RUN; ignores ena0. load_val > limit is accepted unchanged.
- Prescaler: counts 0..DIV-1 while ena0=1 and state=RUN; `step` is true when ena0=1 and prescaler==DIV-1, and the prescaler then returns to 0. DIV=1: step on every enabled cycle.
- Step, dir=1: if cnt ≥ limit, terminal (cnt := 0); else cnt+1.
- Step, dir=0: if cnt == 0, terminal (cnt := limit); else cnt-1.
- Terminal, oneshot=0: wrap as above, tc pulses.
- Terminal, oneshot=1: cnt holds its current value (limit-or-above for up, 0 for down), tc pulses once, done := 1, state := HOLD.
- States: RUN (counting) and HOLD (frozen, done=1). RUN→HOLD on a one-shot terminal step; HOLD→RUN only on clr or load. HOLD ignores ena0, dir, oneshot and limit changes.
- dir, limit and oneshot are sampled at each step; changing them mid-count takes effect at the next step without a reset.
- No overflow beyond WIDTH: limit = 2^WIDTH-1 with dir=1 gives a full-range binary counter.

## Timing
- cnt updates on the edge where step/load/clr is true (zero-latency register).
- out = MSBs of cnt from the previous cycle (one-cycle lag).
- tc is registered and high for exactly the one cycle following the terminal-step edge. It is low in every other cycle, including HOLD.
- done rises on the same edge as tc and stays high until clr/load/rst0.
- Period in wrap mode: (limit+1)·DIV enabled cycles between tc pulses.
- If rst0 is asserted mid-operation, all outputs clear immediately (asynchronously). Deassertion is synchronised externally.
- clr and load in the same cycle: clr wins, cnt=0.
- ena0 low on the cycle that would step: no step, prescaler holds DIV-1, and the step occurs on the next enabled cycle.

## Structure
- Shared package `cnt_pkg`: state enum {RUN, HOLD}, direction constants DIR_UP=1/DIR_DOWN=0, and helper function for prescaler width (max(1, clog2(DIV))).
- Sub-module `tick_gen` (prescaler: clkin, rst0, ena0, sync restart, DIV parameter → step pulse). The counter/FSM, tc/done and the out register stay in the top.

## Test plan
- WIDTH=8, DIV=4, limit=5, dir=1, oneshot=0, ena0=1 from reset → cnt steps every 4 cycles 0..5→0, tc high one cycle after each 5→0 edge, 24 cycles between tc pulses. out tracks cnt[7:4] one cycle late.
- Same settings, dir=0, load load_val=2 → cnt 2,1,0,5,4…, tc after the 0→5 edge. load while ena0=0 still sets cnt=2.
- oneshot=1, dir=1, limit=3 → cnt 0..3 then holds 3, single tc pulse, done=1. Toggling ena0, limit and dir in HOLD causes no change. load then restarts with done=0.
- ena0 deasserted for 10 cycles mid-prescale (prescaler=2) → cnt and prescaler frozen, stepping resumes after exactly 1 more enabled cycle.
- clr and load asserted together with cnt=4 → cnt=0, prescaler=0, tc=0. rst0 pulsed mid-count → cnt, out, tc and done are 0 before the next clkin edge.
- DIV=1, WIDTH=4, limit=15, dir=1 → full-range binary count 0..15, tc once per 16 cycles, out (OUT_BITS=4) equals cnt delayed by one cycle.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types and helpers for the prescaled counter: run/hold state,
// direction encoding and prescaler register sizing.
package cnt_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Prescaler needs at least one bit even when DIV is 1.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle step every DIV enabled cycles and can be
// restarted synchronously from zero.
module tick_gen
  import cnt_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clkin,
  input  logic rst0,
  input  logic ena0,
  input  logic restart,
  output logic step
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;

  assign step = ena0 && (presc == LAST);

  always_ff @(posedge clkin or posedge rst0) begin
    if (rst0) begin
      presc <= '0;
    end else if (restart) begin
      presc <= '0;
    end else if (ena0) begin
      presc <= step ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter with prescaler, programmable wrap limit, load/clear,
// one-shot hold and a lagged MSB output for display drive.
module prescaled_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 27,
  parameter int DIV      = 1,
  parameter int OUT_BITS = 4
) (
  input  logic                clkin,
  input  logic                rst0,
  input  logic                ena0,
  input  logic                clr,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                dir,
  input  logic                oneshot,
  input  logic [WIDTH-1:0]    limit,
  output logic [WIDTH-1:0]    cnt,
  output logic [OUT_BITS-1:0] out,
  output logic                tc,
  output logic                done
);

  state_t state;
  logic   step;
  logic   terminal;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] cnt_wrap;

  tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clkin  (clkin),
    .rst0   (rst0),
    .ena0   (ena0 && (state == RUN)),
    .restart(clr || load),
    .step   (step)
  );

  // Up direction treats anything at or above limit as terminal so an
  // out-of-range load still wraps back into 0..limit.
  assign terminal = (dir == DIR_UP) ? (cnt >= limit) : (cnt == '0);
  assign cnt_next = (dir == DIR_UP) ? cnt + 1'b1 : cnt - 1'b1;
  assign cnt_wrap = (dir == DIR_UP) ? '0 : limit;

  always_ff @(posedge clkin or posedge rst0) begin
    if (rst0) begin
      cnt   <= '0;
      out   <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
    end else begin
      out <= cnt[WIDTH-1 -: OUT_BITS];
      tc  <= 1'b0;
      if (clr) begin
        cnt   <= '0;
        done  <= 1'b0;
        state <= RUN;
      end else if (load) begin
        cnt   <= load_val;
        done  <= 1'b0;
        state <= RUN;
      end else if (step) begin
        if (terminal) begin
          tc <= 1'b1;
          if (oneshot) begin
            done  <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt_wrap;
          end
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge
// monitor pops and compares them against two counter configurations.
module tb_prescaled_counter;

  logic       clkin = 1'b0;
  logic       rst0, ena0, clr, load, dir, oneshot;
  logic [7:0] load_val, limit;
  logic [3:0] load_val2, limit2;

  logic [7:0] cnt1;
  logic [3:0] out1;
  logic       tc1, done1;
  logic [3:0] cnt2;
  logic [3:0] out2;
  logic       tc2, done2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         which;
    int         cyc;
    logic [7:0] cnt;
    logic [3:0] out;
    logic       tc;
    logic       done;
    logic       chk_out;
  } exp_t;

  exp_t sb[$];

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  prescaled_counter #(.WIDTH(8), .DIV(4), .OUT_BITS(4)) dut (
    .clkin(clkin), .rst0(rst0), .ena0(ena0), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .oneshot(oneshot), .limit(limit),
    .cnt(cnt1), .out(out1), .tc(tc1), .done(done1)
  );

  prescaled_counter #(.WIDTH(4), .DIV(1), .OUT_BITS(4)) dut2 (
    .clkin(clkin), .rst0(rst0), .ena0(ena0), .clr(clr), .load(load),
    .load_val(load_val2), .dir(dir), .oneshot(oneshot), .limit(limit2),
    .cnt(cnt2), .out(out2), .tc(tc2), .done(done2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, expv);
    end
  endtask

  // Queue the expected outputs for the state after the next rising edge.
  task automatic tick(input int which, input int c, input int o, input bit t,
                      input bit d, input bit co);
    exp_t e;
    e.which   = which;
    e.cyc     = cyc + 1;
    e.cnt     = 8'(c);
    e.out     = 4'(o);
    e.tc      = t;
    e.done    = d;
    e.chk_out = co;
    sb.push_back(e);
    @(posedge clkin);
    #1;
  endtask

  always @(negedge clkin) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        chk("sb_late", e.cyc, cyc);
      end else if (e.which == 0) begin
        chk("cnt", cnt1, e.cnt);
        if (e.chk_out) chk("out", out1, e.out);
        chk("tc", tc1, e.tc);
        chk("done", done1, e.done);
      end else begin
        chk("cnt2", cnt2, e.cnt);
        if (e.chk_out) chk("out2", out2, e.out);
        chk("tc2", tc2, e.tc);
        chk("done2", done2, e.done);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; ena0 = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b1; oneshot = 1'b0;
    load_val = 8'd0; limit = 8'd5; load_val2 = 4'd0; limit2 = 4'hF;
    #22;
    chk("rst_cnt", cnt1, 0);
    chk("rst_out", out1, 0);
    chk("rst_tc", tc1, 0);
    chk("rst_done", done1, 0);
    chk("rst_cnt2", cnt2, 0);
    @(negedge clkin); #1;
    rst0 = 1'b0; ena0 = 1'b1;

    // Up count, limit 5, DIV 4: step every 4 edges, tc every 24.
    for (int k = 1; k <= 50; k++)
      tick(0, (k / 4) % 6, 0, (k % 24) == 0, 0, 1);

    // Down count after a load taken while disabled.
    ena0 = 1'b0; load = 1'b1; load_val = 8'd2; dir = 1'b0;
    tick(0, 2, 0, 0, 0, 1);
    load = 1'b0; ena0 = 1'b1;
    for (int j = 1; j <= 40; j++)
      tick(0, ((2 - j / 4) % 6 + 6) % 6, 0, (j % 24) == 12, 0, 1);

    // One-shot up to limit 3, then hold.
    oneshot = 1'b1; dir = 1'b1; limit = 8'd3; clr = 1'b1; ena0 = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    clr = 1'b0; ena0 = 1'b1;
    for (int j = 1; j <= 20; j++)
      tick(0, (j / 4 < 3) ? j / 4 : 3, 0, j == 16, j >= 16, 1);
    ena0 = 1'b0;
    repeat (2) tick(0, 3, 0, 0, 1, 1);
    ena0 = 1'b1; limit = 8'd1; dir = 1'b0; oneshot = 1'b0;
    repeat (8) tick(0, 3, 0, 0, 1, 1);
    load = 1'b1; load_val = 8'hA3;
    tick(0, 8'hA3, 0, 0, 0, 1);
    load = 1'b0; ena0 = 1'b0;
    tick(0, 8'hA3, 4'hA, 0, 0, 1);
    limit = 8'd5; dir = 1'b1; oneshot = 1'b0;

    // Enable dropped mid-prescale, then on the step cycle itself.
    clr = 1'b1;
    tick(0, 0, 4'hA, 0, 0, 1);
    clr = 1'b0; ena0 = 1'b1;
    repeat (2) tick(0, 0, 0, 0, 0, 1);
    ena0 = 1'b0;
    repeat (10) tick(0, 0, 0, 0, 0, 1);
    ena0 = 1'b1;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 0, 1);
    repeat (3) tick(0, 1, 0, 0, 0, 1);
    ena0 = 1'b0;
    repeat (3) tick(0, 1, 0, 0, 0, 1);
    ena0 = 1'b1;
    tick(0, 2, 0, 0, 0, 1);

    // clr and load together: clr wins and the prescaler restarts.
    ena0 = 1'b0; load = 1'b1; load_val = 8'd4;
    tick(0, 4, 0, 0, 0, 1);
    load = 1'b0; ena0 = 1'b1;
    repeat (2) tick(0, 4, 0, 0, 0, 1);
    clr = 1'b1; load = 1'b1; load_val = 8'd7;
    tick(0, 0, 0, 0, 0, 1);
    clr = 1'b0; load = 1'b0;
    repeat (3) tick(0, 0, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 0, 1);

    // clr on what would be a terminal step suppresses tc.
    ena0 = 1'b0; load = 1'b1; load_val = 8'd5;
    tick(0, 5, 0, 0, 0, 1);
    load = 1'b0; ena0 = 1'b1;
    repeat (3) tick(0, 5, 0, 0, 0, 1);
    clr = 1'b1;
    tick(0, 0, 0, 0, 0, 1);
    clr = 1'b0;
    tick(0, 0, 0, 0, 0, 1);

    // Load above limit in one-shot: first step is terminal; then async reset.
    ena0 = 1'b0; load = 1'b1; load_val = 8'hB0; oneshot = 1'b1;
    tick(0, 8'hB0, 0, 0, 0, 1);
    load = 1'b0; ena0 = 1'b1;
    repeat (3) tick(0, 8'hB0, 4'hB, 0, 0, 1);
    tick(0, 8'hB0, 4'hB, 1, 1, 1);
    @(negedge clkin); #1;
    rst0 = 1'b1;
    #1;
    chk("arst_cnt", cnt1, 0);
    chk("arst_out", out1, 0);
    chk("arst_tc", tc1, 0);
    chk("arst_done", done1, 0);
    @(negedge clkin); #1;
    rst0 = 1'b0; oneshot = 1'b0; ena0 = 1'b0;

    // DIV 1, 4-bit full-range binary count.
    clr = 1'b1; ena0 = 1'b1; dir = 1'b1;
    tick(1, 0, 0, 0, 0, 0);
    clr = 1'b0;
    for (int j = 1; j <= 34; j++)
      tick(1, j % 16, (j - 1) % 16, (j % 16) == 0, 0, 1);

    repeat (3) @(negedge clkin);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
